line_scheduler: RTL

- Command-driven sequencer that sits between control logic (switches or an animation FSM) and the line_drawer / VGA_framebuffer pair.
- Buffers drawing commands in a small FIFO and executes them one at a time:
  - LINE: starts line_drawer and forwards its pixels to the framebuffer in the command colour.
  - CLEAR: sweeps every pixel itself and writes the command colour.
  - WAIT_FRAME: stalls until frame_start, so erase/redraw animation steps stay frame-aligned.
- Owns the framebuffer write port exclusively.

---
 rtl/line_scheduler_if.sv | 23 ++
 rtl/line_scheduler.sv | 186 ++++++++++++++++++
 2 files changed

// File: rtl/line_scheduler_if.sv
// rtl/line_scheduler_if.sv - command stream into the line scheduler FIFO
interface line_scheduler_if #(
    parameter int CW = 11
);
    logic          cmd_valid;
    logic          cmd_ready;
    logic [1:0]    cmd_op;
    logic          cmd_color;
    logic [CW-1:0] cmd_x0;
    logic [CW-1:0] cmd_y0;
    logic [CW-1:0] cmd_x1;
    logic [CW-1:0] cmd_y1;

    modport master (
        output cmd_valid, cmd_op, cmd_color, cmd_x0, cmd_y0, cmd_x1, cmd_y1,
        input  cmd_ready
    );

    modport slave (
        input  cmd_valid, cmd_op, cmd_color, cmd_x0, cmd_y0, cmd_x1, cmd_y1,
        output cmd_ready
    );
endinterface

// File: rtl/line_scheduler.sv
// rtl/line_scheduler.sv - queued LINE/CLEAR/WAIT_FRAME sequencer owning the framebuffer write port
module line_scheduler #(
    parameter int WIDTH  = 640,
    parameter int HEIGHT = 480,
    parameter int DEPTH  = 4,
    parameter int CW     = 11
) (
    input  logic            clk,
    input  logic            reset,
    line_scheduler_if.slave cmd,
    input  logic            frame_start,
    output logic            ld_start,
    output logic [CW-1:0]   ld_x0,
    output logic [CW-1:0]   ld_y0,
    output logic [CW-1:0]   ld_x1,
    output logic [CW-1:0]   ld_y1,
    input  logic            ld_valid,
    input  logic [CW-1:0]   ld_x,
    input  logic [CW-1:0]   ld_y,
    input  logic            ld_done,
    output logic [CW-1:0]   fb_x,
    output logic [CW-1:0]   fb_y,
    output logic            fb_color,
    output logic            fb_write,
    output logic            busy,
    output logic [15:0]     lines_done
);
    localparam int AW = $clog2(DEPTH);
    localparam logic [AW:0]   FULL_COUNT = (AW+1)'(DEPTH);
    localparam logic [CW-1:0] X_LAST     = CW'(WIDTH - 1);
    localparam logic [CW-1:0] Y_LAST     = CW'(HEIGHT - 1);

    localparam logic [1:0] OP_LINE  = 2'b00;
    localparam logic [1:0] OP_CLEAR = 2'b01;
    localparam logic [1:0] OP_WAIT  = 2'b10;

    typedef struct packed {
        logic [1:0]    op;
        logic          color;
        logic [CW-1:0] x0;
        logic [CW-1:0] y0;
        logic [CW-1:0] x1;
        logic [CW-1:0] y1;
    } cmd_t;

    typedef enum logic [2:0] {
        S_IDLE, S_LOAD, S_START, S_DRAW, S_CLEAR, S_WAIT
    } state_t;

    state_t        state;
    cmd_t          fifo_mem [DEPTH];
    cmd_t          cmd_in;
    cmd_t          head;
    logic [AW-1:0] wr_ptr;
    logic [AW-1:0] rd_ptr;
    logic [AW:0]   count;
    logic          push;
    logic          pop;
    logic [1:0]    cur_op;
    logic [CW-1:0] cx;
    logic [CW-1:0] cy;
    logic [CW-1:0] hold_x;
    logic [CW-1:0] hold_y;

    assign cmd_in = '{op: cmd.cmd_op, color: cmd.cmd_color, x0: cmd.cmd_x0,
                      y0: cmd.cmd_y0, x1: cmd.cmd_x1, y1: cmd.cmd_y1};
    assign head          = fifo_mem[rd_ptr];
    assign cmd.cmd_ready = (count != FULL_COUNT);
    assign push          = cmd.cmd_valid && cmd.cmd_ready;
    assign pop           = (state == S_IDLE) && (count != '0);
    assign busy          = (state != S_IDLE) || (count != '0);

    always_ff @(posedge clk) begin
        if (push) begin
            fifo_mem[wr_ptr] <= cmd_in;
        end
    end

    always_ff @(posedge clk) begin
        if (!reset) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            if (push) wr_ptr <= wr_ptr + 1'b1;
            if (pop)  rd_ptr <= rd_ptr + 1'b1;
            case ({push, pop})
                2'b10:   count <= count + 1'b1;
                2'b01:   count <= count - 1'b1;
                default: count <= count;
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (!reset) begin
            state      <= S_IDLE;
            ld_start   <= 1'b0;
            ld_x0      <= '0;
            ld_y0      <= '0;
            ld_x1      <= '0;
            ld_y1      <= '0;
            fb_color   <= 1'b0;
            cur_op     <= '0;
            cx         <= '0;
            cy         <= '0;
            lines_done <= '0;
        end else begin
            ld_start <= 1'b0;
            case (state)
                S_IDLE: begin
                    if (count != '0) begin
                        cur_op   <= head.op;
                        fb_color <= head.color;
                        ld_x0    <= head.x0;
                        ld_y0    <= head.y0;
                        ld_x1    <= head.x1;
                        ld_y1    <= head.y1;
                        state    <= S_LOAD;
                    end
                end
                S_LOAD: begin
                    case (cur_op)
                        OP_LINE: begin
                            ld_start <= 1'b1;
                            state    <= S_START;
                        end
                        OP_CLEAR: begin
                            cx    <= '0;
                            cy    <= '0;
                            state <= S_CLEAR;
                        end
                        OP_WAIT: state <= S_WAIT;
                        default: state <= S_IDLE;
                    endcase
                end
                S_START: state <= S_DRAW;
                S_DRAW: begin
                    if (ld_done) begin
                        lines_done <= lines_done + 16'd1;
                        state      <= S_IDLE;
                    end
                end
                S_CLEAR: begin
                    if (cx == X_LAST) begin
                        cx <= '0;
                        if (cy == Y_LAST) state <= S_IDLE;
                        else              cy <= cy + 1'b1;
                    end else begin
                        cx <= cx + 1'b1;
                    end
                end
                S_WAIT: begin
                    if (frame_start) state <= S_IDLE;
                end
                default: state <= S_IDLE;
            endcase
        end
    end

    // Coordinates keep the last written pixel so fb_write alone qualifies the port.
    always_ff @(posedge clk) begin
        if (!reset) begin
            hold_x <= '0;
            hold_y <= '0;
        end else if (fb_write) begin
            hold_x <= fb_x;
            hold_y <= fb_y;
        end
    end

    always_comb begin
        fb_write = 1'b0;
        fb_x     = hold_x;
        fb_y     = hold_y;
        if (state == S_DRAW && ld_valid) begin
            fb_write = 1'b1;
            fb_x     = ld_x;
            fb_y     = ld_y;
        end else if (state == S_CLEAR) begin
            fb_write = 1'b1;
            fb_x     = cx;
            fb_y     = cy;
        end
    end
endmodule
